t08_wb_responder: RTL and testbench

// Wishbone classic-cycle responder (slave) for the t08 chip's Wishbone master port.

---
 rtl/t08_wb_responder_if.sv | 23 ++
 rtl/t08_wb_responder.sv | 178 +++++++++++++++++
 tb/tb_t08_wb_responder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t08_wb_responder_if.sv
// Wishbone classic-cycle bus bundle between a bus master and the t08 responder.
// Pure wiring: no state, no latency of its own.
// Flow control lives in the cyc/stb request and the single-cycle ack.
interface t08_wb_responder_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/t08_wb_responder.sv
// Wishbone classic responder backed by a byte-lane-writable word scratchpad with sticky out-of-range flag.
// Latency: ack is high WAIT_STATES+1 cycles after the edge that accepts cyc&stb; spacing WAIT_STATES+2.
// Backpressure: one transfer at a time; requests are only sampled in IDLE, dropping cyc in WAIT aborts.
module t08_wb_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               nRst,
  t08_wb_responder_if.slave  wb,
  output logic               busy,
  output logic               oob_err,
  input  logic               err_clr
);

  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] BASE_W   = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] rdat_q, rdat_d;
  logic        oob_q, oob_d;
  logic [31:0] mem_q [DEPTH];

  logic        req_vld;
  logic        in_idle;
  logic        enter_ack;
  logic [29:0] cur_adr;
  logic [31:0] cur_dat;
  logic [3:0]  cur_sel;
  logic        cur_we;
  logic [29:0] off;
  logic        in_range;
  logic [IW-1:0] idx;
  logic        unused_adr_lsb;

  // Address bits [1:0] carry no information for a word-addressed target.
  assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

  // Request view: live bus fields in IDLE (zero-wait commit), latched fields afterwards.
  always_comb begin
    req_vld  = wb.wb_cyc_i & wb.wb_stb_i;
    in_idle  = (state_q == S_IDLE);
    cur_adr  = in_idle ? wb.wb_adr_i[31:2] : adr_q;
    cur_dat  = in_idle ? wb.wb_dat_i : wdat_q;
    cur_sel  = in_idle ? wb.wb_sel_i : sel_q;
    cur_we   = in_idle ? wb.wb_we_i : we_q;
    off      = cur_adr - BASE_W;
    in_range = (cur_adr >= BASE_W) && (off < DEPTH_W);
    idx      = off[IW-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort on dropped cyc takes priority over the final wait cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb.wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    enter_ack = (state_d == S_ACK) && (state_q != S_ACK);
  end

  // FSM outputs: ack and busy decode straight from state, read data comes from its register.
  always_comb begin
    wb.wb_ack_o = (state_q == S_ACK);
    busy        = (state_q != S_IDLE);
    wb.wb_dat_o = rdat_q;
    oob_err     = oob_q;
  end

  // Next values for the wait counter and the request latch.
  always_comb begin
    cnt_d  = cnt_q;
    adr_d  = adr_q;
    wdat_d = wdat_q;
    sel_d  = sel_q;
    we_d   = we_q;
    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          cnt_d  = WAIT_CNT;
          adr_d  = wb.wb_adr_i[31:2];
          wdat_d = wb.wb_dat_i;
          sel_d  = wb.wb_sel_i;
          we_d   = wb.wb_we_i;
        end
      end
      S_WAIT:  cnt_d = cnt_q - 4'd1;
      default: cnt_d = 4'd0;
    endcase
  end

  // Next values for read data (only non-zero during the ack cycle) and the sticky error flag.
  always_comb begin
    rdat_d = 32'h0;
    if (enter_ack && !cur_we && in_range) begin
      rdat_d = mem_q[idx];
    end
    oob_d = oob_q;
    if (err_clr) begin
      oob_d = 1'b0;
    end
    if (enter_ack && !in_range) begin
      oob_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      cnt_q  <= 4'd0;
      adr_q  <= 30'd0;
      wdat_q <= 32'h0;
      sel_q  <= 4'h0;
      we_q   <= 1'b0;
      rdat_q <= 32'h0;
      oob_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      adr_q  <= adr_d;
      wdat_q <= wdat_d;
      sel_q  <= sel_d;
      we_q   <= we_d;
      rdat_q <= rdat_d;
      oob_q  <= oob_d;
    end
  end

  // Scratchpad: byte-lane write commits on the edge entering ACK; reset discards anything pending.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (enter_ack && cur_we && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (cur_sel[n]) begin
          mem_q[idx][8*n +: 8] <= cur_dat[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_t08_wb_responder.sv
module tb_t08_wb_responder;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic busy, oob_err, err_clr;
  logic busy0, oob_err0, err_clr0;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  t08_wb_responder_if wb_if();
  t08_wb_responder_if wb0_if();

  t08_wb_responder #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_STATES(2)) dut (
    .clk(clk), .nRst(nRst), .wb(wb_if.slave),
    .busy(busy), .oob_err(oob_err), .err_clr(err_clr)
  );

  t08_wb_responder #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nRst(nRst), .wb(wb0_if.slave),
    .busy(busy0), .oob_err(oob_err0), .err_clr(err_clr0)
  );

  always #5 clk = ~clk;

  task automatic idle_bus();
    wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
    wb_if.wb_adr_i = 32'h0; wb_if.wb_dat_i = 32'h0; wb_if.wb_sel_i = 4'h0;
  endtask

  // Single transfer on the 2-wait DUT; reads push their expected data and pop it at ack.
  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp, input string nm);
    int n;
    bit got;
    logic [31:0] e;
    if (!w) exp_q.push_back(exp);
    @(negedge clk);
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = w;
    wb_if.wb_adr_i = a; wb_if.wb_dat_i = d; wb_if.wb_sel_i = s;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (wb_if.wb_ack_o === 1'b1) got = 1;
    end
    total++;
    if (!got || n != 3) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles (ack seen %0d) want 3", nm, n, got);
    end
    if (!w) begin
      e = exp_q.pop_front();
      if (got) begin
        total++;
        if (wb_if.wb_dat_o !== e) begin
          bad++;
          $display("FAIL %s_data: got %h want %h", nm, wb_if.wb_dat_o, e);
        end
      end
    end
    idle_bus();
    @(negedge clk);
    total++;
    if (wb_if.wb_ack_o !== 1'b0 || wb_if.wb_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL %s_after_ack: ack=%b dat=%h want ack=0 dat=0", nm, wb_if.wb_ack_o, wb_if.wb_dat_o);
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (wb_if.wb_ack_o !== 1'b0 || busy !== 1'b0 || oob_err !== 1'b0 || wb_if.wb_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: ack=%b busy=%b oob=%b dat=%h want all 0",
               wb_if.wb_ack_o, busy, oob_err, wb_if.wb_dat_o);
    end
    nRst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_xfer(1'b1, BASE + 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, "basic_wr");
    do_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'hDEADBEEF, "basic_rd");
  endtask

  task automatic test_lanes();
    do_xfer(1'b1, BASE + 32'h8, 32'h0000AA00, 4'b0010, 32'h0, "lane_wr");
    do_xfer(1'b0, BASE + 32'h8, 32'h0, 4'h1, 32'hDEADAAEF, "lane_rd");
    do_xfer(1'b1, BASE + 32'h8, 32'hFFFFFFFF, 4'b0000, 32'h0, "sel0_wr");
    do_xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, 32'hDEADAAEF, "sel0_rd");
    do_xfer(1'b1, BASE + 32'hFC, 32'hCAFEF00D, 4'hF, 32'h0, "last_wr");
    do_xfer(1'b0, BASE + 32'hFF, 32'h0, 4'hF, 32'hCAFEF00D, "last_rd");
    total++;
    if (oob_err !== 1'b0) begin
      bad++;
      $display("FAIL last_word_oob: got %b want 0", oob_err);
    end
  endtask

  task automatic test_oob();
    int n;
    bit got;
    do_xfer(1'b1, BASE + 32'h100, 32'h11111111, 4'hF, 32'h0, "oob_wr");
    do_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, 32'h0, "oob_rd");
    repeat (2) @(negedge clk);
    total++;
    if (oob_err !== 1'b1) begin
      bad++;
      $display("FAIL oob_sticky: got %b want 1", oob_err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (oob_err !== 1'b0) begin
      bad++;
      $display("FAIL oob_clear: got %b want 0", oob_err);
    end
    // err_clr held through an access below BASE: the set on the ack edge must win.
    err_clr = 1'b1;
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b0;
    wb_if.wb_adr_i = BASE - 32'h4; wb_if.wb_sel_i = 4'hF;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (wb_if.wb_ack_o === 1'b1) got = 1;
    end
    total++;
    if (!got || oob_err !== 1'b1 || wb_if.wb_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL oob_set_wins: ack=%0d oob=%b dat=%h want ack=1 oob=1 dat=0", got, oob_err, wb_if.wb_dat_o);
    end
    err_clr = 1'b0;
    idle_bus();
    @(negedge clk);
    total++;
    if (oob_err !== 1'b1) begin
      bad++;
      $display("FAIL oob_hold: got %b want 1", oob_err);
    end
    // The dropped write above must not have aliased onto any in-range word.
    do_xfer(1'b0, BASE, 32'h0, 4'hF, 32'h0, "oob_nowrite_rd");
  endtask

  task automatic test_abort();
    int acks;
    do_xfer(1'b1, BASE, 32'hA5A5A5A5, 4'hF, 32'h0, "abort_pre_wr");
    @(negedge clk);
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b1;
    wb_if.wb_adr_i = BASE; wb_if.wb_dat_i = 32'h12345678; wb_if.wb_sel_i = 4'hF;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_wait: got %b want 1", busy);
    end
    idle_bus();
    wb_if.wb_dat_i = 32'hFFFF0000;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy_low: got %b want 0", busy);
    end
    acks = (wb_if.wb_ack_o === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (wb_if.wb_ack_o === 1'b1) acks++;
    end
    total++;
    if (acks != 0) begin
      bad++;
      $display("FAIL abort_no_ack: got %0d acks want 0", acks);
    end
    do_xfer(1'b0, BASE, 32'h0, 4'hF, 32'hA5A5A5A5, "abort_rd");
  endtask

  task automatic test_back_to_back();
    int acks, last, gap_bad;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hDEADAAEF);
    @(negedge clk);
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b0;
    wb_if.wb_adr_i = BASE + 32'h8; wb_if.wb_sel_i = 4'hF;
    acks = 0; last = -1; gap_bad = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (wb_if.wb_ack_o === 1'b1) begin
        acks++;
        if ((last < 0 && n != 3) || (last >= 0 && n - last != 4)) gap_bad++;
        last = n;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++;
          if (wb_if.wb_dat_o !== e) begin
            bad++;
            $display("FAIL b2b_data: got %h want %h at cycle %0d", wb_if.wb_dat_o, e, n);
          end
        end
      end
    end
    idle_bus();
    total++;
    if (acks != 4 || gap_bad != 0) begin
      bad++;
      $display("FAIL b2b_spacing: acks=%0d bad_gaps=%0d want acks=4 bad_gaps=0", acks, gap_bad);
    end
    exp_q.delete();
  endtask

  task automatic test_zero_wait();
    int acks, last, gap_bad;
    @(negedge clk);
    wb0_if.wb_cyc_i = 1'b1; wb0_if.wb_stb_i = 1'b1; wb0_if.wb_we_i = 1'b1;
    wb0_if.wb_adr_i = BASE + 32'h4; wb0_if.wb_dat_i = 32'h5555AAAA; wb0_if.wb_sel_i = 4'hF;
    acks = 0; last = -1; gap_bad = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (wb0_if.wb_ack_o === 1'b1) begin
        acks++;
        if ((last < 0 && n != 1) || (last >= 0 && n - last != 2)) gap_bad++;
        last = n;
      end
    end
    total++;
    if (acks != 4 || gap_bad != 0) begin
      bad++;
      $display("FAIL zw_spacing: acks=%0d bad_gaps=%0d want acks=4 bad_gaps=0", acks, gap_bad);
    end
    exp_q.push_back(32'h5555AAAA);
    wb0_if.wb_we_i = 1'b0; wb0_if.wb_dat_i = 32'h0;
    @(negedge clk);
    total++;
    if (wb0_if.wb_ack_o !== 1'b1 || wb0_if.wb_dat_o !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL zw_read: ack=%b dat=%h want ack=1 dat=5555aaaa", wb0_if.wb_ack_o, wb0_if.wb_dat_o);
    end
    wb0_if.wb_cyc_i = 1'b0; wb0_if.wb_stb_i = 1'b0;
    @(negedge clk);
    total++;
    if (wb0_if.wb_ack_o !== 1'b0 || wb0_if.wb_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL zw_after_ack: ack=%b dat=%h want 0", wb0_if.wb_ack_o, wb0_if.wb_dat_o);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    @(negedge clk);
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b1;
    wb_if.wb_adr_i = BASE + 32'h10; wb_if.wb_dat_i = 32'h77777777; wb_if.wb_sel_i = 4'hF;
    @(negedge clk);
    nRst = 1'b0;
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      if (wb_if.wb_ack_o === 1'b1) acks++;
    end
    total++;
    if (acks != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ack: acks=%0d busy=%b want 0 0", acks, busy);
    end
    idle_bus();
    nRst = 1'b1;
    @(negedge clk);
    total++;
    if (oob_err !== 1'b0 || busy !== 1'b0 || wb_if.wb_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_state: oob=%b busy=%b ack=%b want 0 0 0", oob_err, busy, wb_if.wb_ack_o);
    end
    do_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'h0, "rstmid_word");
    do_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, 32'h0, "rstmid_clear");
  endtask

  initial begin
    idle_bus();
    err_clr = 1'b0;
    err_clr0 = 1'b0;
    wb0_if.wb_cyc_i = 1'b0; wb0_if.wb_stb_i = 1'b0; wb0_if.wb_we_i = 1'b0;
    wb0_if.wb_adr_i = 32'h0; wb0_if.wb_dat_i = 32'h0; wb0_if.wb_sel_i = 4'h0;
    test_reset();
    test_basic();
    test_lanes();
    test_oob();
    test_abort();
    test_back_to_back();
    test_zero_wait();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
